// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg : shared widths, control-bit indices and slot-update codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_stage_reg_pkg;

  localparam int DEFAULT_DATA_W = 96;
  localparam int DEFAULT_CTRL_W = 16;

  // Bit positions inside the control bundle; an all-zero bundle is a NOP.
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMWRITE  = 1;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_JUMP      = 3;
  localparam int CTRL_ALUOP_LSB = 4;
  localparam int CTRL_ALUOP_W   = 4;

  // What the main entry does at the next edge.
  typedef enum logic [1:0] {
    M_KEEP      = 2'd0,
    M_FROM_IN   = 2'd1,
    M_FROM_SKID = 2'd2,
    M_CLEAR     = 2'd3
  } m_op_e;

  // What the skid entry does at the next edge.
  typedef enum logic [1:0] {
    S_KEEP    = 2'd0,
    S_FROM_IN = 2'd1,
    S_CLEAR   = 2'd2
  } s_op_e;

  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot : one valid+data+ctrl entry with load and clear (clear wins)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_slot #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Clearing drops valid and ctrl but keeps data, so a bubble never carries
  // live control while the datapath simply shows its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= d_data;
      r_ctrl  <= d_ctrl;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign ctrl  = r_ctrl;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg : valid/ready stage register with optional skid, hold, flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              w_m_valid;
  logic [DATA_W-1:0] w_m_data;
  logic [CTRL_W-1:0] w_m_ctrl;
  logic              w_s_valid;
  logic [DATA_W-1:0] w_s_data;
  logic [CTRL_W-1:0] w_s_ctrl;

  logic              w_in_fire;
  logic              w_out_fire;
  m_op_e             w_m_op;
  s_op_e             w_s_op;
  logic [DATA_W-1:0] w_m_d_data;
  logic [CTRL_W-1:0] w_m_d_ctrl;

  assign w_out_fire = w_m_valid & out_ready & ~hold;
  assign w_in_fire  = in_valid & in_ready;

  // Flush overrides everything, including hold and a same-cycle accept.
  always_comb begin
    w_m_op = M_KEEP;
    w_s_op = S_KEEP;
    if (flush) begin
      w_m_op = M_CLEAR;
      w_s_op = S_CLEAR;
    end else if (w_out_fire) begin
      // A valid skid entry forces in_ready low, so no accept can coincide.
      if (w_s_valid) begin
        w_m_op = M_FROM_SKID;
        w_s_op = S_CLEAR;
      end else if (w_in_fire) begin
        w_m_op = M_FROM_IN;
      end else begin
        w_m_op = M_CLEAR;
      end
    end else if (w_in_fire) begin
      if (!w_m_valid) begin
        w_m_op = M_FROM_IN;
      end else begin
        w_s_op = S_FROM_IN;
      end
    end
  end

  always_comb begin
    w_m_d_data = in_data;
    w_m_d_ctrl = in_ctrl;
    if (w_m_op == M_FROM_SKID) begin
      w_m_d_data = w_s_data;
      w_m_d_ctrl = w_s_ctrl;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   ((w_m_op == M_FROM_IN) || (w_m_op == M_FROM_SKID)),
    .clear  (w_m_op == M_CLEAR),
    .d_data (w_m_d_data),
    .d_ctrl (w_m_d_ctrl),
    .valid  (w_m_valid),
    .data   (w_m_data),
    .ctrl   (w_m_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (w_s_op == S_FROM_IN),
        .clear  (w_s_op == S_CLEAR),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (w_s_valid),
        .data   (w_s_data),
        .ctrl   (w_s_ctrl)
      );

      // Registered ready: no combinational path from out_ready.
      assign in_ready = ~w_s_valid;
    end else begin : g_no_skid
      logic w_unused_s_op;

      assign w_s_valid     = 1'b0;
      assign w_s_data      = '0;
      assign w_s_ctrl      = '0;
      assign w_unused_s_op = ^w_s_op;
      assign in_ready      = ~w_m_valid | w_out_fire;
    end
  endgenerate

  assign out_valid = w_m_valid;
  assign out_data  = w_m_data;
  assign out_ctrl  = w_m_valid ? w_m_ctrl : '0;
  assign occupancy = count_valid(w_m_valid, w_s_valid);

  generate
    if (SKID == 0) begin : g_chk_single
      a_single_entry : assert property (@(posedge clk) disable iff (!reset)
        occupancy != 2'd2);
    end
  endgenerate

  a_skid_implies_main : assert property (@(posedge clk) disable iff (!reset)
    w_s_valid |-> w_m_valid);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg : table vectors, corner sequences and random FIFO-model run
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = DEFAULT_DATA_W;
  localparam int CW = DEFAULT_CTRL_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          hold;
  logic          flush;
  logic          out_ready;

  logic          rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_ctrl(in_ctrl), .hold(hold), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_ctrl(in_ctrl), .hold(hold), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0)
  );

  // Reference: a FIFO of capacity 1 or 2; e[0] is the head, last is the
  // datapath value the output keeps showing once the FIFO drains.
  typedef struct packed {
    logic [1:0][CW+DW-1:0] e;
    logic [1:0]            n;
    logic [DW-1:0]         last;
  } model_t;

  model_t m1, m0;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [15:0] c;
    logic       hd, fl, ordy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] occ;
    logic       irdy;
  } vec_t;

  vec_t tbl[40];
  int   n_vec = 0;

  function automatic logic [CW-1:0] mk_ctrl(input logic [7:0] d);
    return {d, 8'h00} | (CW'(1) << CTRL_REGWRITE) | (CW'(1) << CTRL_ALUOP_LSB);
  endfunction

  function automatic logic mdl_ready(input model_t m, input int cap);
    logic ofire;
    ofire = (m.n != 2'd0) && out_ready && !hold;
    if (cap == 2) return m.n < 2'd2;
    return (m.n == 2'd0) || ofire;
  endfunction

  function automatic model_t mdl_step(input model_t m, input int cap);
    logic ofire, ifire;
    ofire = (m.n != 2'd0) && out_ready && !hold;
    ifire = in_valid && mdl_ready(m, cap);
    if (flush) begin
      m.n = 2'd0;
      return m;
    end
    if (ofire) begin
      m.e[0] = m.e[1];
      m.n    = m.n - 2'd1;
    end
    if (ifire) begin
      m.e[m.n[0]] = {in_ctrl, in_data};
      m.n         = m.n + 2'd1;
    end
    if (m.n != 2'd0) m.last = m.e[0][DW-1:0];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input model_t m, input int cap,
                         input logic rdy, input logic ov, input logic [DW-1:0] od,
                         input logic [CW-1:0] oc, input logic [1:0] occ);
    chk({tag, ".in_ready"},  rdy, mdl_ready(m, cap));
    chk({tag, ".out_valid"}, ov,  m.n != 2'd0);
    chk({tag, ".out_data"},  od,  m.last);
    chk({tag, ".out_ctrl"},  oc,  (m.n != 2'd0) ? m.e[0][CW+DW-1:DW] : '0);
    chk({tag, ".occupancy"}, occ, m.n);
  endtask

  // Called just after a rising edge with inputs applied; checks both DUTs
  // against the model before the next edge, then advances one cycle.
  task automatic tick();
    model_t n1, n0;
    #3;
    cmp_dut("skid1", m1, 2, rdy1, ov1, od1, oc1, occ1);
    cmp_dut("skid0", m0, 1, rdy0, ov0, od0, oc0, occ0);
    n1 = mdl_step(m1, 2);
    n0 = mdl_step(m0, 1);
    @(posedge clk);
    #1;
    m1 = n1;
    m0 = n0;
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic [15:0] c,
                     input logic hd, input logic fl, input logic ordy,
                     input logic ov, input logic [7:0] od, input logic [1:0] occ,
                     input logic irdy);
    tbl[n_vec] = '{iv, d, c, hd, fl, ordy, ov, od, occ, irdy};
    n_vec++;
  endtask

  task automatic set_in(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic hd, input logic fl, input logic ordy);
    in_valid = iv; in_data = d; in_ctrl = c; hold = hd; flush = fl; out_ready = ordy;
  endtask

  initial begin
    // Streaming 1..8 then drain
    for (int k = 1; k <= 8; k++)
      add(1, 8'(k), mk_ctrl(8'(k)), 0, 0, 1, 1, 8'(k), 2'd1, 1);
    add(0, 8'h00, 16'h0000, 0, 0, 1, 0, 8'h08, 2'd0, 1);
    // Backpressure A,B,C then release
    add(1, 8'h0A, mk_ctrl(8'h0A), 0, 0, 0, 1, 8'h0A, 2'd1, 1);
    add(1, 8'h0B, mk_ctrl(8'h0B), 0, 0, 0, 1, 8'h0A, 2'd2, 0);
    add(1, 8'h0C, mk_ctrl(8'h0C), 0, 0, 0, 1, 8'h0A, 2'd2, 0);
    add(1, 8'h0C, mk_ctrl(8'h0C), 0, 0, 1, 1, 8'h0B, 2'd1, 1);
    add(1, 8'h0C, mk_ctrl(8'h0C), 0, 0, 1, 1, 8'h0C, 2'd1, 1);
    add(0, 8'h00, 16'h0000, 0, 0, 1, 0, 8'h0C, 2'd0, 1);
    // Hold freezes the output slot
    add(1, 8'h55, mk_ctrl(8'h55), 0, 0, 1, 1, 8'h55, 2'd1, 1);
    add(0, 8'h00, 16'h0000, 1, 0, 1, 1, 8'h55, 2'd1, 1);
    add(0, 8'h00, 16'h0000, 1, 0, 1, 1, 8'h55, 2'd1, 1);
    add(0, 8'h00, 16'h0000, 0, 0, 1, 0, 8'h55, 2'd0, 1);
    // Flush when full, then flush+hold with a same-cycle accept
    add(1, 8'h20, mk_ctrl(8'h20), 0, 0, 0, 1, 8'h20, 2'd1, 1);
    add(1, 8'h21, mk_ctrl(8'h21), 0, 0, 0, 1, 8'h20, 2'd2, 0);
    add(1, 8'h77, mk_ctrl(8'h77), 0, 1, 1, 0, 8'h20, 2'd0, 1);
    add(1, 8'h30, mk_ctrl(8'h30), 0, 0, 0, 1, 8'h30, 2'd1, 1);
    add(1, 8'h77, mk_ctrl(8'h77), 1, 1, 0, 0, 8'h30, 2'd0, 1);
    add(0, 8'h77, mk_ctrl(8'h77), 0, 0, 0, 0, 8'h30, 2'd0, 1);
    // Bubble control is never stored
    add(0, 8'h99, 16'hFFFF, 0, 0, 0, 0, 8'h30, 2'd0, 1);
    add(1, 8'h40, mk_ctrl(8'h40), 0, 0, 1, 1, 8'h40, 2'd1, 1);
    add(0, 8'h99, 16'hFFFF, 0, 0, 1, 0, 8'h40, 2'd0, 1);

    m1 = '0;
    m0 = '0;
    reset = 1'b0;
    set_in(0, '0, '0, 0, 0, 0);
    #12;
    chk("reset.out_valid", ov1, 1'b0);
    chk("reset.out_data", od1, '0);
    chk("reset.out_ctrl", oc1, '0);
    chk("reset.occupancy", occ1, 2'd0);
    chk("reset.in_ready", rdy1, 1'b1);
    chk("reset.in_ready0", rdy0, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < n_vec; i++) begin
      set_in(tbl[i].iv, DW'(tbl[i].d), tbl[i].c, tbl[i].hd, tbl[i].fl, tbl[i].ordy);
      tick();
      chk($sformatf("vec%0d.out_valid", i), ov1, tbl[i].ov);
      chk($sformatf("vec%0d.out_data", i), od1, DW'(tbl[i].od));
      chk($sformatf("vec%0d.out_ctrl", i), oc1, tbl[i].ov ? mk_ctrl(tbl[i].od) : 16'h0000);
      chk($sformatf("vec%0d.occupancy", i), occ1, tbl[i].occ);
      chk($sformatf("vec%0d.in_ready", i), rdy1, tbl[i].irdy);
    end

    // Asynchronous reset while full
    set_in(1, DW'(8'h61), mk_ctrl(8'h61), 0, 0, 0);
    tick();
    set_in(1, DW'(8'h62), mk_ctrl(8'h62), 0, 0, 0);
    tick();
    chk("areset.pre_occupancy", occ1, 2'd2);
    #2 reset = 1'b0;
    #1;
    chk("areset.out_valid", ov1, 1'b0);
    chk("areset.out_ctrl", oc1, '0);
    chk("areset.occupancy", occ1, 2'd0);
    chk("areset.out_data", od1, '0);
    chk("areset.out_valid0", ov0, 1'b0);
    set_in(0, '0, '0, 0, 0, 0);
    #2 reset = 1'b1;
    m1 = '0;
    m0 = '0;
    @(posedge clk);
    #1;
    chk("areset.in_ready_after", rdy1, 1'b1);

    // Single-entry stage: ready follows out_fire combinationally when full
    set_in(1, DW'(8'h81), mk_ctrl(8'h81), 0, 0, 0);
    tick();
    out_ready = 1'b1; hold = 1'b1; in_valid = 1'b0;
    #1;
    chk("skid0.ready_hold", rdy0, 1'b0);
    hold = 1'b0;
    #1;
    chk("skid0.ready_outfire", rdy0, 1'b1);
    set_in(1, DW'(8'h82), mk_ctrl(8'h82), 0, 0, 1);
    tick();
    chk("skid0.replace_data", od0, DW'(8'h82));
    chk("skid0.replace_occ", occ0, 2'd1);

    // Random traffic against the FIFO model
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 9) < 7), {$urandom, $urandom, $urandom}, CW'($urandom),
             ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5),
             ($urandom_range(0, 9) < 6));
      tick();
    end
    set_in(0, '0, '0, 0, 0, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
